// File: rtl/alu_if.sv
// Operand/result bundle between the Mips16 decode logic and the execute-stage ALU.
// The master side supplies the operands and the decoded instruction fields.
// The slave side (the ALU) returns the registered result and the zero flag.
interface alu_if;

    logic [15:0] data_1;
    logic [15:0] data_2;
    logic [2:0]  opcode;
    logic [3:0]  funct;
    logic [15:0] alu_result;
    logic        zero;

    modport master (
        output data_1,
        output data_2,
        output opcode,
        output funct,
        input  alu_result,
        input  zero
    );

    modport slave (
        input  data_1,
        input  data_2,
        input  opcode,
        input  funct,
        output alu_result,
        output zero
    );

endinterface

// File: rtl/alu.sv
// Mips16 execute-stage ALU.
// Decodes opcode/funct into one arithmetic, logic, compare or shift operation.
// The result and zero flag are registered together, so they appear one clock after the inputs.
// Arithmetic wraps modulo 2^16; carry and overflow are dropped.
// Shifts use only the low four bits of operand B.
module alu #(
    parameter int WIDTH = 16
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_RTYPE = 3'd0,
        OP_ADDI  = 3'd1,
        OP_ANDI  = 3'd2,
        OP_ORI   = 3'd3,
        OP_SLTI  = 3'd4,
        OP_BEQ   = 3'd5,
        OP_BNE   = 3'd6,
        OP_MEM   = 3'd7
    } opcode_e;

    typedef enum logic [3:0] {
        FN_ADD  = 4'd0,
        FN_SUB  = 4'd1,
        FN_AND  = 4'd2,
        FN_OR   = 4'd3,
        FN_XOR  = 4'd4,
        FN_NOR  = 4'd5,
        FN_SLT  = 4'd6,
        FN_SLTU = 4'd7,
        FN_SLL  = 4'd8,
        FN_SRL  = 4'd9,
        FN_SRA  = 4'd10
    } funct_e;

    logic [WIDTH-1:0] w_opA;
    logic [WIDTH-1:0] w_opB;
    logic [3:0]       w_shamt;
    logic             w_signedLess;
    logic             w_unsignedLess;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_nextResult;
    logic             w_nextZero;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    assign w_opA   = bus.data_1;
    assign w_opB   = bus.data_2;
    assign w_shamt = bus.data_2[3:0];

    // Shared adder, subtractor and comparators reused by several opcodes.
    always_comb begin
        w_sum          = w_opA + w_opB;
        w_diff         = w_opA - w_opB;
        w_signedLess   = $signed(w_opA) < $signed(w_opB);
        w_unsignedLess = w_opA < w_opB;
    end

    // Decode opcode/funct into the next result; undefined functs give zero.
    always_comb begin
        w_nextResult = '0;
        case (opcode_e'(bus.opcode))
            OP_RTYPE: begin
                case (funct_e'(bus.funct))
                    FN_ADD:  w_nextResult = w_sum;
                    FN_SUB:  w_nextResult = w_diff;
                    FN_AND:  w_nextResult = w_opA & w_opB;
                    FN_OR:   w_nextResult = w_opA | w_opB;
                    FN_XOR:  w_nextResult = w_opA ^ w_opB;
                    FN_NOR:  w_nextResult = ~(w_opA | w_opB);
                    FN_SLT:  w_nextResult = {{(WIDTH-1){1'b0}}, w_signedLess};
                    FN_SLTU: w_nextResult = {{(WIDTH-1){1'b0}}, w_unsignedLess};
                    FN_SLL:  w_nextResult = w_opA << w_shamt;
                    FN_SRL:  w_nextResult = w_opA >> w_shamt;
                    FN_SRA:  w_nextResult = WIDTH'($signed(w_opA) >>> w_shamt);
                    default: w_nextResult = '0;
                endcase
            end
            OP_ADDI: w_nextResult = w_sum;
            OP_ANDI: w_nextResult = w_opA & w_opB;
            OP_ORI:  w_nextResult = w_opA | w_opB;
            OP_SLTI: w_nextResult = {{(WIDTH-1){1'b0}}, w_signedLess};
            OP_BEQ:  w_nextResult = w_diff;
            OP_BNE:  w_nextResult = w_diff;
            OP_MEM:  w_nextResult = w_sum;
            default: w_nextResult = '0;
        endcase
    end

    // The zero flag is derived from the same next result so both registers always agree.
    always_comb begin
        w_nextZero = (w_nextResult == '0);
    end

    // Result register; a reset edge forces a zero result with the zero flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            r_result <= w_nextResult;
            r_zero   <= w_nextZero;
        end
    end

    assign bus.alu_result = r_result;
    assign bus.zero       = r_zero;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the Mips16 ALU.
// A reference model computes each result with plain integer arithmetic.
// Directed vectors carry hand-computed results that check both the DUT and the model.
// A long randomized stream, with occasional resets, follows the directed vectors.
module tb_alu;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    // Literal expectation attached to the inputs currently driven.
    logic        hasLit  = 1'b0;
    logic [15:0] litRes  = 16'h0000;
    string       litName = "none";

    // Expectations captured at the edge that samples the inputs.
    logic        expValid   = 1'b0;
    logic [15:0] expRes     = 16'h0000;
    logic        expZero    = 1'b1;
    logic        litValidQ  = 1'b0;
    logic [15:0] litResQ    = 16'h0000;
    string       litNameQ   = "none";

    alu_if bus ();

    alu #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: works on non-negative ints and keeps only the low 16 bits.
    function automatic logic [15:0] refModel(input int op, input int fn, input int a, input int b);
        int sa;
        int sb;
        int p;
        int r;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        p  = 1 << (b % 16);
        r  = 0;
        case (op)
            0: begin
                case (fn)
                    0:  r = a + b;
                    1:  r = a - b + 65536;
                    2:  r = a & b;
                    3:  r = a | b;
                    4:  r = a ^ b;
                    5:  r = 65535 - (a | b);
                    6:  r = (sa < sb) ? 1 : 0;
                    7:  r = (a < b) ? 1 : 0;
                    8:  r = a * p;
                    9:  r = a / p;
                    10: r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
                    default: r = 0;
                endcase
            end
            1: r = a + b;
            2: r = a & b;
            3: r = a | b;
            4: r = (sa < sb) ? 1 : 0;
            5: r = a - b + 65536;
            6: r = a - b + 65536;
            7: r = a + b;
            default: r = 0;
        endcase
        return 16'(r);
    endfunction

    // Model side: capture what the DUT must show after this edge.
    always @(posedge clk) begin
        expValid  <= 1'b1;
        if (rst) begin
            expRes  <= 16'h0000;
            expZero <= 1'b1;
        end else begin
            expRes  <= refModel(int'(bus.opcode), int'(bus.funct), int'(bus.data_1), int'(bus.data_2));
            expZero <= (refModel(int'(bus.opcode), int'(bus.funct), int'(bus.data_1), int'(bus.data_2)) == 16'h0000);
        end
        litValidQ <= hasLit;
        litResQ   <= litRes;
        litNameQ  <= litName;
    end

    task automatic checkOutput(input string name, input logic [15:0] wantRes, input logic wantZero);
        checks++;
        if (bus.alu_result !== wantRes || bus.zero !== wantZero) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got result=%h zero=%b, expected result=%h zero=%b",
                     name, $time, bus.alu_result, bus.zero, wantRes, wantZero);
        end
    endtask

    // Compare process: every cycle against the model, plus literal pins when present.
    always @(negedge clk) begin
        if (expValid) begin
            checkOutput("model", expRes, expZero);
            if (litValidQ) begin
                checkOutput(litNameQ, litResQ, (litResQ == 16'h0000));
                checks++;
                if (expRes !== litResQ) begin
                    errors++;
                    $display("[TB] FAIL modelpin_%s: model gave %h, hand value %h", litNameQ, expRes, litResQ);
                end
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic [2:0] op, input logic [3:0] fn,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic lit, input logic [15:0] want, input string name);
        @(negedge clk);
        rst            = r;
        bus.opcode     = op;
        bus.funct      = fn;
        bus.data_1     = a;
        bus.data_2     = b;
        hasLit         = lit;
        litRes         = want;
        litName        = name;
    endtask

    initial begin
        bus.opcode = 3'($urandom);
        bus.funct  = 4'($urandom);
        bus.data_1 = 16'($urandom);
        bus.data_2 = 16'($urandom);
        hasLit     = 1'b1;
        litRes     = 16'h0000;
        litName    = "reset0";

        applyStimulus(1'b1, 3'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 1'b1, 16'h0000, "reset1");

        applyStimulus(1'b0, 3'd0, 4'd0,  16'h0003, 16'h0004, 1'b1, 16'h0007, "add");
        applyStimulus(1'b0, 3'd0, 4'd1,  16'h0005, 16'h0005, 1'b1, 16'h0000, "sub_eq");
        applyStimulus(1'b0, 3'd0, 4'd2,  16'hF0F0, 16'hFF00, 1'b1, 16'hF000, "and");
        applyStimulus(1'b0, 3'd0, 4'd3,  16'hF0F0, 16'h0F0F, 1'b1, 16'hFFFF, "or");
        applyStimulus(1'b0, 3'd0, 4'd4,  16'hF0F0, 16'hFF00, 1'b1, 16'h0FF0, "xor");
        applyStimulus(1'b0, 3'd0, 4'd5,  16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, "nor");
        applyStimulus(1'b0, 3'd0, 4'd6,  16'h8000, 16'h0001, 1'b1, 16'h0001, "slt");
        applyStimulus(1'b0, 3'd0, 4'd7,  16'h8000, 16'h0001, 1'b1, 16'h0000, "sltu");
        applyStimulus(1'b0, 3'd4, 4'd9,  16'hFFFE, 16'hFFFF, 1'b1, 16'h0001, "slti");
        applyStimulus(1'b0, 3'd0, 4'd8,  16'h0001, 16'h000F, 1'b1, 16'h8000, "sll15");
        applyStimulus(1'b0, 3'd0, 4'd9,  16'h8000, 16'h0004, 1'b1, 16'h0800, "srl");
        applyStimulus(1'b0, 3'd0, 4'd10, 16'h8000, 16'h0004, 1'b1, 16'hF800, "sra");
        applyStimulus(1'b0, 3'd0, 4'd10, 16'h4000, 16'hFFF2, 1'b1, 16'h1000, "sra_pos");
        applyStimulus(1'b0, 3'd0, 4'd8,  16'h1234, 16'h0010, 1'b1, 16'h1234, "sll0");
        applyStimulus(1'b0, 3'd5, 4'd3,  16'h1234, 16'h1234, 1'b1, 16'h0000, "beq");
        applyStimulus(1'b0, 3'd6, 4'd0,  16'h1234, 16'h1235, 1'b1, 16'hFFFF, "bne");
        applyStimulus(1'b0, 3'd7, 4'd1,  16'h0010, 16'hFFFC, 1'b1, 16'h000C, "lwsw");
        applyStimulus(1'b0, 3'd1, 4'd7,  16'hFFFF, 16'h0001, 1'b1, 16'h0000, "addi_wrap");
        applyStimulus(1'b0, 3'd0, 4'd0,  16'h7FFF, 16'h0001, 1'b1, 16'h8000, "add_ovf");
        applyStimulus(1'b0, 3'd0, 4'd1,  16'h0000, 16'h0001, 1'b1, 16'hFFFF, "sub_under");
        applyStimulus(1'b0, 3'd2, 4'd0,  16'h1234, 16'h00FF, 1'b1, 16'h0034, "andi");
        applyStimulus(1'b0, 3'd3, 4'd0,  16'h1200, 16'h0034, 1'b1, 16'h1234, "ori");
        applyStimulus(1'b0, 3'd0, 4'd13, 16'h1234, 16'h5678, 1'b1, 16'h0000, "illegal_funct");
        applyStimulus(1'b1, 3'd0, 4'd0,  16'h1111, 16'h2222, 1'b1, 16'h0000, "midreset");
        applyStimulus(1'b0, 3'd0, 4'd0,  16'h1111, 16'h2222, 1'b1, 16'h3333, "resume");

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0), 3'($urandom), 4'($urandom),
                          ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom),
                          ($urandom_range(0, 7) == 0) ? 16'h0001 : 16'($urandom),
                          1'b0, 16'h0000, "none");
        end

        applyStimulus(1'b0, 3'd0, 4'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000, "none");
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
